// File: rtl/axil_selftest_pkg.sv
// Shared types and constants for the AXI-Lite self-test initiator.
// Holds the run state encoding, error codes and AXI response values.
package axil_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_MAGIC_A = 3'd1,
    ST_RD_MAGIC_R = 3'd2,
    ST_WR_AW_W    = 3'd3,
    ST_WR_B       = 3'd4,
    ST_RD_SCR_A   = 3'd5,
    ST_RD_SCR_R   = 3'd6,
    ST_DONE       = 3'd7
  } state_e;

  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_MAGIC    = 3'd1;
  localparam logic [2:0] ERR_RRESP    = 3'd2;
  localparam logic [2:0] ERR_BRESP    = 3'd3;
  localparam logic [2:0] ERR_READBACK = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/axil_txn_timer.sv
// Per-state watchdog: counts the cycles spent in one transaction state.
// clear_i marks the first cycle of a new state; expired_o flags the TIMEOUT_CYC-th cycle.
module axil_txn_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: the current cycle is already counted when a state is entered.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i) begin
      cnt_d = {CW{1'b0}};
    end else if (clear_i) begin
      cnt_d = CW'(1);
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (clear_i ? (TIMEOUT_CYC == 1) : (cnt_q >= CNT_LAST));

endmodule

// File: rtl/axil_selftest_master.sv
// AXI-Lite initiator that reads a magic register, writes a scratch register and reads it back,
// reporting pass/fail, an error code and a saturating pass count.
module axil_selftest_master
  import axil_selftest_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] CHECK_ADDR   = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] SCRATCH_ADDR = 32'h0000_0004,
  parameter logic [DATA_WIDTH-1:0] EXP_MAGIC    = 32'h0011_4514,
  parameter logic [DATA_WIDTH-1:0] PATTERN      = 32'hA5C3_5A3C,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    sys_clk,
  input  logic                    perif_rst,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [2:0]              err_code,
  output logic [DATA_WIDTH-1:0]   err_data,
  output logic [15:0]             pass_cnt
);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, err_data_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                    aw_done_q, w_done_q, tmr_clr_q;
  logic                    busy_q, done_q, pass_q;
  logic [2:0]              err_code_q;
  logic [15:0]             pass_cnt_q;

  logic                    expired_s, tmr_en_s, aw_fin_s, w_fin_s;
  logic                    fin_s;
  logic [2:0]              fin_code_s;
  logic [DATA_WIDTH-1:0]   fin_data_s;

  assign tmr_en_s = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign aw_fin_s = aw_done_q || (awvalid_q && m_axil_awready);
  assign w_fin_s  = w_done_q  || (wvalid_q  && m_axil_wready);

  axil_txn_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk_i     (sys_clk),
    .rst_i     (perif_rst),
    .clear_i   (tmr_clr_q),
    .enable_i  (tmr_en_s),
    .expired_o (expired_s)
  );

  // Decide whether this cycle ends the run, and with which code and data.
  always_comb begin
    fin_s      = 1'b0;
    fin_code_s = ERR_OK;
    fin_data_s = {DATA_WIDTH{1'b0}};
    if (expired_s) begin
      fin_s      = 1'b1;
      fin_code_s = ERR_TIMEOUT;
    end else begin
      case (state_q)
        ST_RD_MAGIC_R: begin
          if (m_axil_rvalid && (m_axil_rresp != AXI_RESP_OKAY)) begin
            fin_s      = 1'b1;
            fin_code_s = ERR_RRESP;
          end else if (m_axil_rvalid && (m_axil_rdata != EXP_MAGIC)) begin
            fin_s      = 1'b1;
            fin_code_s = ERR_MAGIC;
            fin_data_s = m_axil_rdata;
          end else begin
            fin_s = 1'b0;
          end
        end
        ST_WR_B: begin
          if (m_axil_bvalid && (m_axil_bresp != AXI_RESP_OKAY)) begin
            fin_s      = 1'b1;
            fin_code_s = ERR_BRESP;
          end else begin
            fin_s = 1'b0;
          end
        end
        ST_RD_SCR_R: begin
          if (!m_axil_rvalid) begin
            fin_s = 1'b0;
          end else if (m_axil_rresp != AXI_RESP_OKAY) begin
            fin_s      = 1'b1;
            fin_code_s = ERR_RRESP;
          end else if (m_axil_rdata != PATTERN) begin
            fin_s      = 1'b1;
            fin_code_s = ERR_READBACK;
            fin_data_s = m_axil_rdata;
          end else begin
            fin_s = 1'b1;
          end
        end
        default: fin_s = 1'b0;
      endcase
    end
  end

  // Run sequencer with registered AXI and status outputs.
  always_ff @(posedge sys_clk or posedge perif_rst) begin
    if (perif_rst) begin
      state_q    <= ST_IDLE;
      awaddr_q   <= {ADDR_WIDTH{1'b0}};
      araddr_q   <= {ADDR_WIDTH{1'b0}};
      wdata_q    <= {DATA_WIDTH{1'b0}};
      wstrb_q    <= {(DATA_WIDTH/8){1'b0}};
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      tmr_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_code_q <= ERR_OK;
      err_data_q <= {DATA_WIDTH{1'b0}};
      pass_cnt_q <= 16'h0000;
    end else begin
      tmr_clr_q <= 1'b0;
      if (fin_s) begin
        // Errors, timeouts and the final good read all land here; nothing else is issued.
        awvalid_q  <= 1'b0;
        wvalid_q   <= 1'b0;
        bready_q   <= 1'b0;
        arvalid_q  <= 1'b0;
        rready_q   <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        pass_q     <= (fin_code_s == ERR_OK);
        err_code_q <= fin_code_s;
        err_data_q <= fin_data_s;
        if (fin_code_s == ERR_OK) begin
          pass_cnt_q <= sat_inc16(pass_cnt_q);
        end
        state_q   <= ST_DONE;
        tmr_clr_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              done_q     <= 1'b0;
              pass_q     <= 1'b0;
              err_code_q <= ERR_OK;
              err_data_q <= {DATA_WIDTH{1'b0}};
              busy_q     <= 1'b1;
              arvalid_q  <= 1'b1;
              araddr_q   <= CHECK_ADDR;
              state_q    <= ST_RD_MAGIC_A;
              tmr_clr_q  <= 1'b1;
            end
          end
          ST_RD_MAGIC_A: begin
            if (m_axil_arready) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= ST_RD_MAGIC_R;
              tmr_clr_q <= 1'b1;
            end
          end
          ST_RD_MAGIC_R: begin
            if (m_axil_rvalid) begin
              rready_q  <= 1'b0;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              awaddr_q  <= SCRATCH_ADDR;
              wdata_q   <= PATTERN;
              wstrb_q   <= {(DATA_WIDTH/8){1'b1}};
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= ST_WR_AW_W;
              tmr_clr_q <= 1'b1;
            end
          end
          ST_WR_AW_W: begin
            if (awvalid_q && m_axil_awready) begin
              awvalid_q <= 1'b0;
              aw_done_q <= 1'b1;
            end
            if (wvalid_q && m_axil_wready) begin
              wvalid_q <= 1'b0;
              w_done_q <= 1'b1;
            end
            if (aw_fin_s && w_fin_s) begin
              bready_q  <= 1'b1;
              state_q   <= ST_WR_B;
              tmr_clr_q <= 1'b1;
            end
          end
          ST_WR_B: begin
            if (m_axil_bvalid) begin
              bready_q  <= 1'b0;
              arvalid_q <= 1'b1;
              araddr_q  <= SCRATCH_ADDR;
              state_q   <= ST_RD_SCR_A;
              tmr_clr_q <= 1'b1;
            end
          end
          ST_RD_SCR_A: begin
            if (m_axil_arready) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= ST_RD_SCR_R;
              tmr_clr_q <= 1'b1;
            end
          end
          ST_RD_SCR_R: state_q <= ST_RD_SCR_R;
          default:     state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_code       = err_code_q;
  assign err_data       = err_data_q;
  assign pass_cnt       = pass_cnt_q;

endmodule

// File: doc/axil_selftest_master.md
Name: axil_selftest_master

Overview:
AXI-Lite initiator that exercises an AXI-Lite responder from the fabric side. It is the active end of the check path whose passive end is the magic-number register slave. On a start pulse it performs three transactions: read the magic register and compare it, write a scratch register, then read the scratch register back and compare it. It reports pass/fail, an error code and a saturating pass count to role logic or a status register.

Parameters:
ADDR_WIDTH, 32, AXI-Lite address width
DATA_WIDTH, 32, AXI-Lite data width (only 32 supported)
CHECK_ADDR, 'h0, byte address of the magic register
SCRATCH_ADDR, 'h4, byte address of the scratch register
EXP_MAGIC, 'h00114514, expected magic value
PATTERN, 'hA5C3_5A3C, scratch write pattern
TIMEOUT_CYC, 1024, maximum cycles spent in any one transaction state; width is $clog2(TIMEOUT_CYC+1)

Ports:
sys_clk  in  1  clock
perif_rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle run request
m_axil  master  axi_lite(CHANNEL=1, DATA_WIDTH)  signals: awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready
busy  out  1  run in progress
done  out  1  run finished; held high until the next accepted start
pass  out  1  last run passed; valid when done=1
err_code  out  3  0 OK, 1 magic mismatch, 2 RRESP not OKAY, 3 BRESP not OKAY, 4 readback mismatch, 5 timeout
err_data  out  DATA_WIDTH  offending rdata for codes 1 and 4, otherwise 0
pass_cnt  out  16  number of passing runs, saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): state IDLE. All valid/ready outputs, busy, done, pass, err_code, err_data and pass_cnt go to 0. Address and data outputs go to 0.
- FSM states: IDLE, RD_MAGIC_A, RD_MAGIC_R, WR_AW_W, WR_B, RD_SCR_A, RD_SCR_R, DONE.
- IDLE or DONE with start=1: clear done/pass/err_code/err_data, set busy, go to RD_MAGIC_A. start is ignored in every other state.
- RD_MAGIC_A: arvalid=1, araddr=CHECK_ADDR. On arvalid&arready, go to RD_MAGIC_R.
- RD_MAGIC_R: rready=1. On rvalid:
  - rresp!=2'b00 gives err 2.
  - Otherwise rdata!=EXP_MAGIC gives err 1 and err_data=rdata.
  - Otherwise go to WR_AW_W.
- WR_AW_W: awvalid=1 and wvalid=1 assert in the same cycle. awaddr=SCRATCH_ADDR, wdata=PATTERN, wstrb=4'hF. Each valid drops independently after its own handshake; per-channel flags track completion. Go to WR_B only when both have handshaken, including both in the same cycle.
- WR_B: bready=1. On bvalid, bresp!=OKAY gives err 3; otherwise go to RD_SCR_A.
- RD_SCR_A / RD_SCR_R: same as the magic read, with araddr=SCRATCH_ADDR. A data mismatch against PATTERN gives err 4.
- Any error: latch err_code and go to DONE immediately. No further transactions are issued.
- DONE: busy=0, done=1. pass=1 only if err_code==0; on pass, pass_cnt increments once, saturating.
- Valid is never deasserted before its handshake, except on timeout.
- Timeout:
  - A counter clears on every state change and increments each cycle otherwise.
  - When the count reaches TIMEOUT_CYC: err 5, all valid/ready drop, go to DONE.
  - This is a deliberate fatal exit; the responder domain must be reset before the next start.
- Latency with a zero-wait responder (ready held high, response the cycle after the address handshake): start sampled in cycle 0, done=1 in cycle 7.
- Reset mid-operation: outputs clear at once, regardless of any handshake in flight.
- Simultaneous start and reset: reset wins.

Decomposition:
- Package axil_selftest_pkg: state enum, err_code localparams, AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
- Sub-module axil_txn_timer: clear/enable inputs, expired output, TIMEOUT_CYC parameter.

Test Plan:
1. Responder returns magic 32'h00114514 and has a RAM scratch register; start -> done=1 at cycle 7, pass=1, err_code=0, pass_cnt=1. Second start -> pass_cnt=2.
2. Magic read returns 32'hDEADBEEF -> err_code=1, err_data=32'hDEADBEEF, pass=0, awvalid never asserted.
3. bresp=2'b10 -> err_code=3, pass=0, arvalid not asserted after WR_B.
4. awready delayed 5 cycles, wready immediate -> wvalid high exactly 1 cycle, awvalid high 6 cycles, run passes. Repeat with the delays swapped.
5. arready tied 0, TIMEOUT_CYC=16 -> arvalid drops after 16 cycles in RD_MAGIC_A, err_code=5, done=1.
6. perif_rst asserted while in WR_B -> all outputs 0 in the same cycle; after release, a start gives a full pass.
